// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared state encoding and constants for the transmit arbiter
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        ACK       = 3'd4
    } arb_state_t;

    localparam int FRAME_CNT_W        = 16;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first set request at or after ptr, with wrap
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [ID_W-1:0]    o_winner,
    output logic               o_valid
);

    // Scan from the farthest slot back toward ptr so the closest hit wins.
    always_comb begin
        o_winner = '0;
        o_valid  = |i_req;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req[(int'(i_ptr) + i) % NUM_REQ]) begin
                o_winner = ID_W'((int'(i_ptr) + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_xmit_arb.sv
// rtl/uart_xmit_arb.sv - shares one u_xmit among NUM_REQ producers; UART_ARB_TIMEOUT_EN adds a frame watchdog
module uart_xmit_arb
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
`ifdef UART_ARB_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
`endif
    parameter int ID_W = 2
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_l,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     ack,
    output logic [ID_W-1:0]        gnt_id,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
`ifdef UART_ARB_TIMEOUT_EN
    output logic                   timeout_err,
`endif
    output logic                   xmitH,
    output logic [7:0]             xmit_dataH,
    input  logic                   xmit_doneH
);

    arb_state_t             r_state;
    logic [ID_W-1:0]        r_ptr;
    logic [ID_W-1:0]        r_gnt_id;
    logic [NUM_REQ-1:0]     r_ack;
    logic                   r_busy;
    logic                   r_xmit;
    logic [7:0]             r_data;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;

    logic [ID_W-1:0]        w_winner;
    logic                   w_valid;
    logic [NUM_REQ-1:0]     w_ack_vec;
    logic [ID_W-1:0]        w_next_ptr;

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0]            r_wdog;
    logic                   r_to_hit;
    logic                   r_timeout_err;
    logic                   w_wdog_expired;

    assign w_wdog_expired = (r_wdog == 16'(TIMEOUT_CYCLES - 1));
    assign timeout_err    = r_timeout_err;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    assign w_ack_vec  = NUM_REQ'(1) << r_gnt_id;
    assign w_next_ptr = (r_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : r_gnt_id + 1'b1;

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_gnt_id    <= '0;
            r_ack       <= '0;
            r_busy      <= 1'b0;
            r_xmit      <= 1'b0;
            r_data      <= 8'h00;
            r_frame_cnt <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            r_wdog        <= '0;
            r_to_hit      <= 1'b0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_ack  <= '0;
            r_xmit <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Only start when the transmitter reports idle, so a launch is never lost.
                    if (w_valid && xmit_doneH) begin
                        r_gnt_id <= w_winner;
                        r_data   <= req_data[8*w_winner +: 8];
                        r_busy   <= 1'b1;
                        r_xmit   <= 1'b1;
                        r_state  <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_state <= WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
                    r_wdog   <= '0;
                    r_to_hit <= 1'b0;
`endif
                end
                WAIT_BUSY: begin
                    if (!xmit_doneH) begin
                        r_state <= WAIT_DONE;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (w_wdog_expired) begin
                        r_state       <= ACK;
                        r_ack         <= w_ack_vec;
                        r_to_hit      <= 1'b1;
                        r_timeout_err <= 1'b1;
                    end
                    r_wdog <= r_wdog + 16'd1;
`endif
                end
                WAIT_DONE: begin
                    if (xmit_doneH) begin
                        r_state <= ACK;
                        r_ack   <= w_ack_vec;
`ifdef UART_ARB_TIMEOUT_EN
                        r_timeout_err <= 1'b0;
`endif
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (w_wdog_expired) begin
                        r_state       <= ACK;
                        r_ack         <= w_ack_vec;
                        r_to_hit      <= 1'b1;
                        r_timeout_err <= 1'b1;
                    end
                    r_wdog <= r_wdog + 16'd1;
`endif
                end
                ACK: begin
                    r_busy  <= 1'b0;
                    r_ptr   <= w_next_ptr;
                    r_state <= IDLE;
`ifdef UART_ARB_TIMEOUT_EN
                    if (!r_to_hit) begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                    end
`else
                    r_frame_cnt <= r_frame_cnt + 1'b1;
`endif
                end
                default: begin
                    r_state     <= IDLE;
                    r_ptr       <= '0;
                    r_gnt_id    <= '0;
                    r_busy      <= 1'b0;
                    r_data      <= 8'h00;
                    r_frame_cnt <= '0;
`ifdef UART_ARB_TIMEOUT_EN
                    r_wdog        <= '0;
                    r_to_hit      <= 1'b0;
                    r_timeout_err <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign ack        = r_ack;
    assign gnt_id     = r_gnt_id;
    assign busy       = r_busy;
    assign frame_cnt  = r_frame_cnt;
    assign xmitH      = r_xmit;
    assign xmit_dataH = r_data;

endmodule

// File: tb/tb_uart_xmit_arb.sv
// tb/tb_uart_xmit_arb.sv - self-checking bench with a serial transmitter model and round-robin reference
module tb_uart_xmit_arb;

    localparam int N             = 4;
    localparam int BENCH_TIMEOUT = 16;

    logic             sys_clk = 1'b0;
    logic             sys_rst_l = 1'b0;
    logic [N-1:0]     req = '0;
    logic [8*N-1:0]   req_data = '0;
    logic [N-1:0]     ack;
    logic [1:0]       gnt_id;
    logic             busy;
    logic [15:0]      frame_cnt;
    logic             xmitH;
    logic [7:0]       xmit_dataH;
    logic             xmit_doneH;
`ifdef UART_ARB_TIMEOUT_EN
    logic             timeout_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    uart_xmit_arb #(
        .NUM_REQ (N),
`ifdef UART_ARB_TIMEOUT_EN
        .TIMEOUT_CYCLES (BENCH_TIMEOUT),
`endif
        .ID_W    (2)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_l  (sys_rst_l),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .gnt_id     (gnt_id),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
`ifdef UART_ARB_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .xmitH      (xmitH),
        .xmit_dataH (xmit_dataH),
        .xmit_doneH (xmit_doneH)
    );

    // Transmitter model: one bit per clock, start + 8 data LSB-first + stop.
    logic       tx_done, tx_line;
    logic [9:0] tx_sh;
    int         tx_left;
    logic       hold_low = 1'b0;
    logic       hold_high = 1'b0;

    always @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            tx_done <= 1'b1;
            tx_line <= 1'b1;
            tx_sh   <= '1;
            tx_left <= 0;
        end else if (xmitH && tx_done) begin
            tx_done <= 1'b0;
            tx_sh   <= {1'b1, xmit_dataH, 1'b0};
            tx_left <= 10;
        end else if (tx_left > 0) begin
            tx_line <= tx_sh[0];
            tx_sh   <= {1'b1, tx_sh[9:1]};
            tx_left <= tx_left - 1;
        end else if (!tx_done) begin
            tx_done <= 1'b1;
        end
    end

    assign xmit_doneH = hold_low ? 1'b0 : (hold_high ? 1'b1 : tx_done);

    logic [7:0] rx_q[$];
    int         rx_bit = -1;
    logic [7:0] rx_sh;

    always @(negedge sys_clk) begin
        if (!sys_rst_l) begin
            rx_bit = -1;
        end else if (rx_bit < 0) begin
            if (tx_line == 1'b0) rx_bit = 0;
        end else if (rx_bit < 8) begin
            rx_sh[rx_bit] = tx_line;
            rx_bit++;
        end else begin
            if (tx_line) rx_q.push_back(rx_sh);
            rx_bit = -1;
        end
    end

    function automatic int rr_pick(input logic [N-1:0] pend, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (pend[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_l = 1'b0;
        req       = '0;
        hold_low  = 1'b0;
        hold_high = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_l = 1'b1;
        rx_q.delete();
    endtask

    task automatic wait_ack(output logic [N-1:0] seen);
        int n;
        @(negedge sys_clk);
        n = 1;
        while (ack == '0 && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        seen = ack;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ack, busy, xmitH} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: ack=%b busy=%b xmitH=%b required 0", ack, busy, xmitH);
        end
        checks++;
        if (frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt);
        end
        checks++;
        if (gnt_id !== 2'd0 || xmit_dataH !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: gnt_id=%0d data=%h required 0/00", gnt_id, xmit_dataH);
        end
    endtask

    task automatic test_single();
        logic [N-1:0] seen;
        int           extra;
        do_reset();
        req_data[7:0] = 8'hA5;
        req           = 4'b0001;
        @(negedge sys_clk);
        checks++;
        if (xmitH !== 1'b1 || busy !== 1'b1 || gnt_id !== 2'd0 || xmit_dataH !== 8'hA5) begin
            errors++;
            $display("FAIL single_launch: xmitH=%b busy=%b gnt=%0d data=%h required 1/1/0/a5",
                     xmitH, busy, gnt_id, xmit_dataH);
        end
        @(negedge sys_clk);
        checks++;
        if (xmitH !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse_width: xmitH=%b required 0", xmitH);
        end
        wait_ack(seen);
        req = '0;
        checks++;
        if (seen !== 4'b0001) begin
            errors++;
            $display("FAIL single_ack: got %b required 0001", seen);
        end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
            errors++;
            $display("FAIL single_serial: got %0d bytes first=%h required 1 byte a5", rx_q.size(),
                     (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
        @(negedge sys_clk);
        checks++;
        if (frame_cnt !== 16'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: frame_cnt=%0d busy=%b required 1/0", frame_cnt, busy);
        end
        extra = 0;
        repeat (20) begin
            @(negedge sys_clk);
            if (ack != '0 || xmitH) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL single_no_repeat: got %0d extra ack/xmit cycles required 0", extra);
        end
    endtask

    task automatic test_all_four();
        logic [N-1:0] seen;
        logic [7:0]   exp_bytes[5];
        int           bad;
        do_reset();
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req      = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack(seen);
            if (k == 4) req = '0;
            checks++;
            if (seen !== (4'b0001 << (k % 4))) begin
                errors++;
                $display("FAIL all_four_order[%0d]: ack=%b required %b", k, seen, 4'b0001 << (k % 4));
            end
        end
        @(negedge sys_clk);
        checks++;
        if (frame_cnt !== 16'd5) begin
            errors++;
            $display("FAIL all_four_frame_cnt: got %0d required 5", frame_cnt);
        end
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        bad = (rx_q.size() != 5) ? 1 : 0;
        for (int k = 0; k < 5 && bad == 0; k++) if (rx_q[k] !== exp_bytes[k]) bad = 1;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL all_four_serial: got %p required 11 22 33 44 11", rx_q);
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] seen;
        do_reset();
        req_data = {8'hC3, 8'h00, 8'h00, 8'h5A};
        req      = 4'b0001;
        @(negedge sys_clk);
        req[3] = 1'b1;
        wait_ack(seen);
        checks++;
        if (seen !== 4'b0001) begin
            errors++;
            $display("FAIL fair_first: ack=%b required 0001", seen);
        end
        wait_ack(seen);
        checks++;
        if (seen !== 4'b1000 || gnt_id !== 2'd3) begin
            errors++;
            $display("FAIL fair_second: ack=%b gnt=%0d required 1000/3", seen, gnt_id);
        end
        req[3] = 1'b0;
        wait_ack(seen);
        req = '0;
        checks++;
        if (seen !== 4'b0001) begin
            errors++;
            $display("FAIL fair_third: ack=%b required 0001", seen);
        end
    endtask

    task automatic test_done_low();
        logic [N-1:0] seen;
        int           early;
        do_reset();
        hold_low = 1'b1;
        req      = 4'b0010;
        early    = 0;
        repeat (12) begin
            @(negedge sys_clk);
            if (xmitH || busy) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL done_low_hold: got %0d busy/xmit cycles required 0", early);
        end
        hold_low = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (xmitH !== 1'b1 || gnt_id !== 2'd1) begin
            errors++;
            $display("FAIL done_low_release: xmitH=%b gnt=%0d required 1/1", xmitH, gnt_id);
        end
        wait_ack(seen);
        req = '0;
        checks++;
        if (seen !== 4'b0010) begin
            errors++;
            $display("FAIL done_low_ack: ack=%b required 0010", seen);
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] seen;
        int           n;
        do_reset();
        req_data = {8'h00, 8'h00, 8'hF0, 8'h0F};
        req      = 4'b0011;
        n = 0;
        while (!xmitH && n < 50) begin
            @(negedge sys_clk);
            n++;
        end
        repeat (4) @(negedge sys_clk);
        checks++;
        if (busy !== 1'b1 || xmit_doneH !== 1'b0) begin
            errors++;
            $display("FAIL mid_precond: busy=%b doneH=%b required 1/0", busy, xmit_doneH);
        end
        sys_rst_l = 1'b0;
        req[0]    = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || xmitH !== 1'b0 || ack !== '0 || frame_cnt !== 16'd0 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL mid_async_reset: busy=%b xmitH=%b ack=%b cnt=%0d gnt=%0d required all 0",
                     busy, xmitH, ack, frame_cnt, gnt_id);
        end
        @(negedge sys_clk);
        sys_rst_l = 1'b1;
        rx_q.delete();
        wait_ack(seen);
        req = '0;
        checks++;
        if (seen !== 4'b0010 || rx_q.size() != 1 || rx_q[0] !== 8'hF0) begin
            errors++;
            $display("FAIL mid_after_release: ack=%b bytes=%0d required 0010 with one byte f0",
                     seen, rx_q.size());
        end
    endtask

    task automatic test_random();
        logic [N-1:0] pend, exp_vec;
        logic [7:0]   dat[N];
        int           ptr, exp, n, xcnt, unstable;
        logic [7:0]   dval, rx_b;
        bit           seen_x;
        do_reset();
        ptr  = 0;
        pend = N'($urandom_range(1, (1 << N) - 1));
        for (int i = 0; i < N; i++) begin
            dat[i] = 8'($urandom);
            req_data[8*i +: 8] = dat[i];
        end
        req = pend;
        for (int f = 0; f < 30; f++) begin
            exp = rr_pick(pend, ptr);
            exp_vec = '0;
            exp_vec[exp] = 1'b1;
            n = 0; xcnt = 0; unstable = 0; seen_x = 0; dval = 8'h00;
            @(negedge sys_clk);
            while (ack == '0 && n < 200) begin
                if (xmitH) begin
                    xcnt++;
                    if (!seen_x) dval = xmit_dataH;
                    seen_x = 1;
                    if ($urandom_range(0, 3) == 0) req[exp] = 1'b0;
                end else if (seen_x && busy && xmit_dataH !== dval) begin
                    unstable++;
                end
                @(negedge sys_clk);
                n++;
            end
            checks++;
            if (ack !== exp_vec) begin
                errors++;
                $display("FAIL rand_ack[%0d]: ack=%b required %b", f, ack, exp_vec);
            end
            checks++;
            if (xcnt != 1 || unstable != 0) begin
                errors++;
                $display("FAIL rand_launch[%0d]: xmit pulses=%0d data changes=%0d required 1/0",
                         f, xcnt, unstable);
            end
            rx_b = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            checks++;
            if (rx_b !== dat[exp]) begin
                errors++;
                $display("FAIL rand_byte[%0d]: serial=%h required %h", f, rx_b, dat[exp]);
            end
            pend[exp] = 1'b0;
            ptr = (exp + 1) % N;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    dat[i]  = 8'($urandom);
                end
            end
            if (pend == '0) begin
                exp = int'($urandom_range(0, N - 1));
                pend[exp] = 1'b1;
                dat[exp]  = 8'($urandom);
            end
            for (int i = 0; i < N; i++) req_data[8*i +: 8] = dat[i];
            req = pend;
        end
        req = '0;
        @(negedge sys_clk);
        checks++;
        if (frame_cnt !== 16'd30) begin
            errors++;
            $display("FAIL rand_frame_cnt: got %0d required 30", frame_cnt);
        end
    endtask

`ifdef UART_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [N-1:0] seen;
        int           n;
        do_reset();
        hold_high = 1'b1;
        req       = 4'b0100;
        n = 0;
        while (!xmitH && n < 50) begin
            @(negedge sys_clk);
            n++;
        end
        n = 0;
        @(negedge sys_clk);
        n = 1;
        while (ack == '0 && n < 100) begin
            @(negedge sys_clk);
            n++;
        end
        req = '0;
        checks++;
        if (ack !== 4'b0100 || n != BENCH_TIMEOUT + 1) begin
            errors++;
            $display("FAIL timeout_ack: ack=%b after %0d cycles required 0100 after %0d",
                     ack, n, BENCH_TIMEOUT + 1);
        end
        @(negedge sys_clk);
        checks++;
        if (timeout_err !== 1'b1 || frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL timeout_flag: err=%b cnt=%0d required 1/0", timeout_err, frame_cnt);
        end
        hold_high = 1'b0;
        repeat (15) @(negedge sys_clk);
        req = 4'b0001;
        wait_ack(seen);
        req = '0;
        @(negedge sys_clk);
        checks++;
        if (seen !== 4'b0001 || timeout_err !== 1'b0 || frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL timeout_clear: ack=%b err=%b cnt=%0d required 0001/0/1",
                     seen, timeout_err, frame_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_done_low();
        test_reset_mid();
        test_random();
`ifdef UART_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
